// File: rtl/li_expand.sv
// Load-immediate expander: turns a 32-bit constant into the MIPS LUI/ORI pair that rebuilds it.
// Define LI_SHORT_EN to drop the redundant word when either half of the constant is zero.
module li_expand (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic [4:0]  in_rt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT_HI,
        EMIT_LO
    } state_t;

    state_t      state;
    logic [15:0] lo_q;
    logic [4:0]  rt_q;

    function automatic logic [31:0] lui_word(input logic [4:0] rt, input logic [15:0] imm);
        return {6'b001111, 5'd0, rt, imm};
    endfunction

    function automatic logic [31:0] ori_word(input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [15:0] imm);
        return {6'b001101, rs, rt, imm};
    endfunction

    assign in_ready = (state == IDLE);

    // The upper half goes straight into the LUI word at acceptance, so only the
    // lower half needs holding for the ORI word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lo_q      <= '0;
            rt_q      <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        lo_q      <= in_value[15:0];
                        rt_q      <= in_rt;
                        out_valid <= 1'b1;
`ifdef LI_SHORT_EN
                        if (in_value[31:16] == 16'h0000) begin
                            state     <= EMIT_LO;
                            out_instr <= ori_word(5'd0, in_rt, in_value[15:0]);
                            out_last  <= 1'b1;
                        end else begin
                            state     <= EMIT_HI;
                            out_instr <= lui_word(in_rt, in_value[31:16]);
                            out_last  <= (in_value[15:0] == 16'h0000);
                        end
`else
                        state     <= EMIT_HI;
                        out_instr <= lui_word(in_rt, in_value[31:16]);
                        out_last  <= 1'b0;
`endif
                    end
                end
                EMIT_HI: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_instr <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            state     <= EMIT_LO;
                            out_instr <= ori_word(rt_q, rt_q, lo_q);
                            out_last  <= 1'b1;
                        end
                    end
                end
                EMIT_LO: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_instr <= '0;
                        out_last  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_instr <= '0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_li_expand.sv
// Scoreboard bench for li_expand: expected words are queued when a request is
// driven and compared as the block presents them.
module tb_li_expand;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_value = '0;
    logic [4:0]  in_rt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_last;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [32:0] sb[$];   // {last, instr}

    li_expand dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_rt     (in_rt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic void push_expected(input logic [31:0] v, input logic [4:0] rt);
        logic [31:0] lui;
        logic [31:0] ori_rt;
        logic [31:0] ori_zero;
        lui      = 32'h3C00_0000 | (32'(rt) << 16) | (v >> 16);
        ori_rt   = 32'h3400_0000 | (32'(rt) << 21) | (32'(rt) << 16) | (v & 32'h0000_FFFF);
        ori_zero = 32'h3400_0000 | (32'(rt) << 16) | (v & 32'h0000_FFFF);
`ifdef LI_SHORT_EN
        if ((v >> 16) == 32'd0) begin
            sb.push_back({1'b1, ori_zero});
        end else if ((v & 32'h0000_FFFF) == 32'd0) begin
            sb.push_back({1'b1, lui});
        end else begin
            sb.push_back({1'b0, lui});
            sb.push_back({1'b1, ori_rt});
        end
`else
        sb.push_back({1'b0, lui});
        sb.push_back({1'b1, ori_rt});
        if (ori_zero == 32'hFFFF_FFFF) sb.push_back('0);
`endif
    endfunction

    // Must be entered just after a falling edge; returns just after a falling edge.
    task automatic run_req(input logic [31:0] v, input logic [4:0] rt,
                           input int unsigned stall, input bit toggle);
        int unsigned cycles;
        int unsigned left;
        logic [32:0] exp;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_value = v;
        in_rt    = rt;
        out_ready = 1'b0;
        push_expected(v, rt);
        @(negedge clk);
        in_valid = toggle;
        left = stall;
        cycles = 0;
        while (sb.size() != 0 && cycles < 40) begin
            out_ready = (left == 0);
            if (toggle) begin
                in_value = $urandom;
                in_rt    = 5'($urandom);
            end
            exp = sb[0];
            n_cmp++;
            if (out_valid !== 1'b1 || out_instr !== exp[31:0] || out_last !== exp[32]) begin
                n_err++;
                $display("FAIL word v=%h: valid=%b instr=%h last=%b required valid=1 instr=%h last=%b",
                         v, out_valid, out_instr, out_last, exp[31:0], exp[32]);
            end
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL busy_ready: in_ready=%b required 0", in_ready);
            end
            if (left == 0) void'(sb.pop_front());
            else left--;
            @(negedge clk);
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL timeout: %0d words outstanding required 0", sb.size());
            sb.delete();
        end
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after: ready=%b valid=%b instr=%h last=%b required 1 0 00000000 0",
                     in_ready, out_valid, out_instr, out_last);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: valid=%b instr=%h last=%b ready=%b required 0 00000000 0 1",
                     out_valid, out_instr, out_last, in_ready);
        end
        rst = 1'b0;
        // first acceptance on the first rising edge after release
        run_req(32'h1234_5678, 5'd8, 0, 1'b0);
    endtask

    task automatic test_basic();
        run_req(32'h0000_ABCD, 5'd9, 0, 1'b0);
        run_req(32'hFFFF_0000, 5'd2, 0, 1'b0);
        run_req(32'h0000_0000, 5'd2, 0, 1'b0);
        run_req(32'hFFFF_FFFF, 5'd31, 0, 1'b0);
        run_req(32'h8000_0001, 5'd0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_req(32'h1234_5678, 5'd8, 5, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            logic [31:0] v;
            v = $urandom;
            if (i == 3) v = v & 32'h0000_FFFF;
            if (i == 7) v = v & 32'hFFFF_0000;
            run_req(v, 5'($urandom), $urandom_range(0, 2), i[0]);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_value = 32'h1234_5678;
        in_rt    = 5'd8;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_instr !== 32'h3508_5678 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_lo: valid=%b instr=%h required 1 35085678", out_valid, out_instr);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: valid=%b instr=%h last=%b required 0 00000000 0",
                     out_valid, out_instr, out_last);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL discarded: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
        run_req(32'h0001_0002, 5'd3, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
